// File: rtl/dw_pkg.sv
// Shared defaults and FSM state encoding for the depthwise window generator.
package dw_pkg;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int CHANNEL_NUM_DEF = 18;
  localparam int ROW_LEN_MAX_DEF = 318;
  localparam int ROW_NUM_MAX_DEF = 318;

  localparam logic IDLE_ENC = 1'b0;
  localparam logic RUN_ENC  = 1'b1;

  typedef enum logic {
    IDLE = IDLE_ENC,
    RUN  = RUN_ENC
  } state_t;

endpackage

// File: rtl/dw_pos_tracker.sv
// Column/row position tracker: counts accepted beats, latches the frame
// geometry, and classifies the current beat (legal window, last window of
// the row, last beat of the frame).
module dw_pos_tracker #(
  parameter int COL_W = 9,
  parameter int ROW_W = 9
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             beat,
  input  logic [COL_W-1:0] row_len,
  input  logic [ROW_W-1:0] row_num,
  input  logic             stride2,
  output logic             beat_legal,
  output logic             beat_last_col,
  output logic             beat_frame_end
);

  logic [COL_W-1:0] row_len_reg;
  logic [ROW_W-1:0] row_num_reg;
  logic             stride2_reg;
  logic [COL_W-1:0] col_cnt_reg;
  logic [ROW_W-1:0] row_cnt_reg;

  logic col_at_end;
  logic row_at_end;
  logic col_ok;
  logic row_ok;

  // Classify the beat from the current counters. For stride 2, (cnt-2) even
  // is the same as cnt even, so only bit 0 is inspected.
  always_comb begin
    col_at_end     = (col_cnt_reg == row_len_reg - COL_W'(1));
    row_at_end     = (row_cnt_reg == row_num_reg - ROW_W'(1));
    col_ok         = (col_cnt_reg >= COL_W'(2)) && (!stride2_reg || !col_cnt_reg[0]);
    row_ok         = (row_cnt_reg >= ROW_W'(2)) && (!stride2_reg || !row_cnt_reg[0]);
    beat_legal     = col_ok && row_ok;
    // With stride 2 and an even row length the final column is never legal,
    // so the end-of-row flag moves to the column before it.
    beat_last_col  = beat_legal &&
                     (col_at_end ||
                      (stride2_reg && !row_len_reg[0] &&
                       (col_cnt_reg == row_len_reg - COL_W'(2))));
    beat_frame_end = col_at_end && row_at_end;
  end

  // Latch geometry on start; advance col/row counters on every accepted beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      row_len_reg <= '0;
      row_num_reg <= '0;
      stride2_reg <= 1'b0;
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
    end else if (start) begin
      row_len_reg <= row_len;
      row_num_reg <= row_num;
      stride2_reg <= stride2;
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
    end else if (beat) begin
      if (col_at_end) begin
        col_cnt_reg <= '0;
        row_cnt_reg <= row_at_end ? '0 : row_cnt_reg + ROW_W'(1);
      end else begin
        col_cnt_reg <= col_cnt_reg + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/dw_window_gen.sv
// Depthwise 3x3 window generator: shifts 3-row pixel columns into a
// three-deep column register and emits windows at legal stride-1/stride-2
// positions with end-of-row and end-of-frame flags.
// Optional build macro DW_WIN_PERF_CNT_EN adds a win_count output that
// counts emitted windows per frame.
module dw_window_gen
  import dw_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int CHANNEL_NUM = CHANNEL_NUM_DEF,
  parameter int ROW_LEN_MAX = ROW_LEN_MAX_DEF,
  parameter int ROW_NUM_MAX = ROW_NUM_MAX_DEF,
  parameter int COL_W       = $clog2(ROW_LEN_MAX),
  parameter int ROW_W       = $clog2(ROW_NUM_MAX)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                frame_start,
  input  logic [COL_W-1:0]                    row_len,
  input  logic [ROW_W-1:0]                    row_num,
  input  logic                                stride2,
  input  logic [CHANNEL_NUM*3*DATA_WIDTH-1:0] col_in,
  input  logic                                col_valid_in,
  output logic [CHANNEL_NUM*9*DATA_WIDTH-1:0] win_out,
  output logic                                win_valid,
  output logic                                win_last_col,
  output logic                                frame_done
`ifdef DW_WIN_PERF_CNT_EN
  ,
  output logic [31:0]                         win_count
`endif
);

  localparam int COL_WORD_W = CHANNEL_NUM * 3 * DATA_WIDTH;

  state_t state_reg;
  state_t state_next;

  logic [COL_WORD_W-1:0] c0_reg;
  logic [COL_WORD_W-1:0] c1_reg;
  logic [COL_WORD_W-1:0] c2_reg;

  logic beat;
  logic beat_legal;
  logic beat_last_col;
  logic beat_frame_end;

  // A beat counts only while running; frame_start takes priority and drops it.
  assign beat = (state_reg == RUN) && col_valid_in && !frame_start;

  dw_pos_tracker #(
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_pos (
    .clk            (clk),
    .rstn           (rstn),
    .start          (frame_start),
    .beat           (beat),
    .row_len        (row_len),
    .row_num        (row_num),
    .stride2        (stride2),
    .beat_legal     (beat_legal),
    .beat_last_col  (beat_last_col),
    .beat_frame_end (beat_frame_end)
  );

  // Next-state logic: frame_start (re)starts from any state; the final beat
  // of the frame returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (frame_start) state_next = RUN;
      RUN: begin
        if (frame_start)                   state_next = RUN;
        else if (beat && beat_frame_end)   state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Column shift register and registered window outputs. The shift register
  // is not cleared at row boundaries; stale columns are masked by legality.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      c0_reg       <= '0;
      c1_reg       <= '0;
      c2_reg       <= '0;
      win_out      <= '0;
      win_valid    <= 1'b0;
      win_last_col <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      win_valid    <= beat && beat_legal;
      win_last_col <= beat && beat_last_col;
      frame_done   <= beat && beat_frame_end;
      if (beat) begin
        c2_reg <= c1_reg;
        c1_reg <= c0_reg;
        c0_reg <= col_in;
        if (beat_legal) win_out <= {c1_reg, c0_reg, col_in};
      end
    end
  end

`ifdef DW_WIN_PERF_CNT_EN
  logic [31:0] win_count_reg;
  assign win_count = win_count_reg;

  // Per-frame window counter; holds after the frame completes.
  always_ff @(posedge clk) begin
    if (!rstn)            win_count_reg <= '0;
    else if (frame_start) win_count_reg <= '0;
    else if (win_valid)   win_count_reg <= win_count_reg + 32'd1;
  end
`endif

endmodule
